// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and an internal baud tick
// Samples mid-bit, emits one-cycle done/frame-error pulses and holds the last good byte.
module uart_rx #(
   parameter int NB_DATA   = 8,
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 19200,
   parameter int SB_TICKS  = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rx_done_tick,
   output logic               o_frame_error,
   output logic               o_busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int BW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = ($clog2(SB_TICKS) > 4) ? $clog2(SB_TICKS) : 4;
   localparam int NW      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         sync_q;
   logic [BW-1:0]      baud_q, baud_d;
   logic [SW-1:0]      s_cnt_q, s_cnt_d;
   logic [NW-1:0]      n_cnt_q, n_cnt_d;
   logic [NB_DATA-1:0] shreg_q, shreg_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               done_q, done_d;
   logic               ferr_q, ferr_d;
   logic               busy_q, busy_d;
   logic               rx_s;
   logic               tick;
   logic               stop_sample;

   assign rx_s        = sync_q[1];
   assign tick        = (baud_q == BW'(DIV - 1));
   assign baud_d      = tick ? '0 : baud_q + 1'b1;
   assign stop_sample = (state_q == STOP) && tick && (s_cnt_q == SW'(SB_TICKS - 1));

   // Synchroniser resets to the idle line level so reset release never looks like a start bit.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         baud_q  <= '0;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], i_rx};
         baud_q  <= baud_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      shreg_d = shreg_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt_q == SW'(7)) begin
                  s_cnt_d = '0;
                  n_cnt_d = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt_q == SW'(15)) begin
                  s_cnt_d = '0;
                  shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
                  if (n_cnt_q == NW'(NB_DATA - 1)) state_d = STOP;
                  else                             n_cnt_d = n_cnt_q + 1'b1;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_cnt_q == SW'(SB_TICKS - 1)) begin
                  s_cnt_d = '0;
                  state_d = rx_s ? IDLE : WAIT_HIGH;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done_d = stop_sample && rx_s;
      ferr_d = stop_sample && !rx_s;
      data_d = (stop_sample && rx_s) ? shreg_q : data_q;
      busy_d = (state_d != IDLE);
   end

   assign o_data         = data_q;
   assign o_rx_done_tick = done_q;
   assign o_frame_error  = ferr_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with an expected-byte scoreboard
// DIV=10, so one bit on the line lasts 160 clocks.
module tb_uart_rx;

   localparam int BIT_CLKS = 160;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       done;
   logic       ferr;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx #(
      .NB_DATA  (8),
      .CLK_FREQ (1600000),
      .BAUD_RATE(10000),
      .SB_TICKS (16)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_rx          (rx),
      .o_data        (data),
      .o_rx_done_tick(done),
      .o_frame_error (ferr),
      .o_busy        (busy)
   );

   typedef struct {
      logic [7:0]  d;
      int unsigned t;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int          ferr_exp = 0;
   int          done_cnt = 0;
   int          ferr_cnt = 0;
   logic        prev_done = 1'b0;
   logic        prev_ferr = 1'b0;
   exp_t        mon_e;
   int unsigned lat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Pulse monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         check("done_excl_ferr", {31'd0, ferr}, 32'd0);
         check("done_width", {31'd0, prev_done}, 32'd0);
         check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            lat = cyc - mon_e.t;
            check("rx_data", {24'd0, data}, {24'd0, mon_e.d});
            check("latency_in_window", {31'd0, (lat >= 1510 && lat <= 1550)}, 32'd1);
         end
      end
      if (ferr) begin
         ferr_cnt++;
         check("ferr_width", {31'd0, prev_ferr}, 32'd0);
         check("ferr_expected", {31'd0, ferr_exp > 0}, 32'd1);
         if (ferr_exp > 0) ferr_exp--;
      end
      prev_done = done;
      prev_ferr = ferr;
   end

   task automatic line_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
      exp_t e;
      e.d = b;
      e.t = cyc;
      if (push) sb.push_back(e);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(stop);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_ferr", {31'd0, ferr}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2000) @(negedge clk);
      check("idle_no_done", done_cnt, 32'd0);
      check("idle_no_ferr", ferr_cnt, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      send_frame(8'hA5, 1'b1, 1'b1);
      wait_drain();
      check("a5_done_count", done_cnt, 32'd1);
      check("a5_no_ferr", ferr_cnt, 32'd0);
      check("a5_data_hold", {24'd0, data}, 32'hA5);

      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      wait_drain();
      check("b2b_done_count", done_cnt, 32'd4);
      check("b2b_data_hold", {24'd0, data}, 32'h3C);

      rx = 1'b0;
      repeat (40) @(negedge clk);
      check("glitch_busy_high", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_back_idle", {31'd0, busy}, 32'd0);
      check("glitch_data_hold", {24'd0, data}, 32'h3C);
      check("glitch_no_done", done_cnt, 32'd4);
      check("glitch_no_ferr", ferr_cnt, 32'd0);

      ferr_exp = 1;
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (500) @(negedge clk);
      check("ferr_count", ferr_cnt, 32'd1);
      check("ferr_consumed", ferr_exp, 32'd0);
      check("ferr_data_hold", {24'd0, data}, 32'h3C);
      check("ferr_wait_high_busy", {31'd0, busy}, 32'd1);
      check("ferr_no_done", done_cnt, 32'd4);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("ferr_release_idle", {31'd0, busy}, 32'd0);
      send_frame(8'h12, 1'b1, 1'b1);
      wait_drain();
      check("post_ferr_data", {24'd0, data}, 32'h12);
      check("post_ferr_done_count", done_cnt, 32'd5);
      check("post_ferr_ferr_count", ferr_cnt, 32'd1);

      line_bit(1'b0);
      line_bit(1'b1);
      line_bit(1'b0);
      line_bit(1'b0);
      line_bit(1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_data", {24'd0, data}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_ferr", {31'd0, ferr}, 32'd0);
      @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("midrst_no_done", done_cnt, 32'd5);
      check("midrst_idle", {31'd0, busy}, 32'd0);
      send_frame(8'h81, 1'b1, 1'b1);
      wait_drain();
      check("post_rst_data", {24'd0, data}, 32'h81);
      check("post_rst_done_count", done_cnt, 32'd6);
      check("final_ferr_count", ferr_cnt, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
